// File: rtl/scr1_memif_pkg.sv
// scr1_memif_pkg: memory-interface response encoding plus imem arbiter state/ID types
package scr1_memif_pkg;
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_HOLD = 1'b1
  } type_scr1_imem_arb_state_e;
  localparam int SCR1_IMEM_ARB_ID_W = 1;
  typedef logic [SCR1_IMEM_ARB_ID_W-1:0] type_scr1_imem_arb_id_t;
endpackage

// File: rtl/scr1_imem_arb_idfifo.sv
// scr1_imem_arb_idfifo: in-order FIFO of originator port IDs for outstanding imem requests
// Ports: push/push_id enqueue, pop dequeues head_id; full, empty and cnt report occupancy.
module scr1_imem_arb_idfifo
  import scr1_memif_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  type_scr1_imem_arb_id_t push_id,
  input  logic                   pop,
  output type_scr1_imem_arb_id_t head_id,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  type_scr1_imem_arb_id_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    full     = cnt_q == CW'(DEPTH);
    empty    = cnt_q == '0;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_id;
    wr_ptr_d = do_push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    head_id  = mem_q[rd_ptr_q];
    cnt      = cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/scr1_imem_arb.sv
// scr1_imem_arb: two-master arbiter onto the single SCR1 imem port with in-order response routing
// Ports: m0_*/m1_* master request/ack/response, s_* downstream imem port, outst_cnt outstanding count.
// Macro SCR1_IMEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed port-0 priority.
module scr1_imem_arb
  import scr1_memif_pkg::*;
#(
  parameter int OUTST_DEPTH = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int CW = $clog2(OUTST_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_req_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_resp,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_req_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_resp,
  output logic          s_req,
  output logic [AW-1:0] s_addr,
  input  logic          s_req_ack,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_resp,
  output logic [CW-1:0] outst_cnt
);
  type_scr1_imem_arb_state_e state_q, state_d;
  type_scr1_imem_arb_id_t    held_id_q, held_id_d, win_id, sel_id, head_id;
  logic                      sel_req, full, empty, accept, pop;
`ifdef SCR1_IMEM_ARB_RR_EN
  type_scr1_imem_arb_id_t rr_q, rr_d;
  always_comb begin
    win_id = (m0_req & m1_req) ? rr_q : m1_req;
    rr_d   = accept ? ~sel_id : rr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`else
  always_comb begin
    win_id = ~m0_req & m1_req;
  end
`endif
  // Outputs are forced to idle while rst is high since the path is combinational.
  always_comb begin
    sel_id     = (state_q == ARB_HOLD) ? held_id_q : win_id;
    sel_req    = sel_id[0] ? m1_req : m0_req;
    s_req      = sel_req & ~full & ~rst;
    s_addr     = rst ? '0 : (sel_id[0] ? m1_addr : m0_addr);
    accept     = s_req & s_req_ack;
    m0_req_ack = accept & ~sel_id[0];
    m1_req_ack = accept & sel_id[0];
    pop        = ~rst & ~empty & (s_resp != SCR1_MEM_RESP_NOTRDY);
    m0_resp    = (pop & ~head_id[0]) ? s_resp : SCR1_MEM_RESP_NOTRDY;
    m1_resp    = (pop & head_id[0]) ? s_resp : SCR1_MEM_RESP_NOTRDY;
    m0_rdata   = (pop & ~head_id[0]) ? s_rdata : '0;
    m1_rdata   = (pop & head_id[0]) ? s_rdata : '0;
    state_d    = (state_q == ARB_FREE) ? ((s_req & ~s_req_ack) ? ARB_HOLD : ARB_FREE)
                                       : ((accept | ~sel_req) ? ARB_FREE : ARB_HOLD);
    held_id_d  = (state_q == ARB_FREE) ? win_id : held_id_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_FREE;
      held_id_q <= '0;
    end else begin
      state_q   <= state_d;
      held_id_q <= held_id_d;
    end
  end
  scr1_imem_arb_idfifo #(.DEPTH(OUTST_DEPTH)) i_idfifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (sel_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (full),
    .empty   (empty),
    .cnt     (outst_cnt)
  );
endmodule

// File: tb/tb_scr1_imem_arb.sv
// tb_scr1_imem_arb: directed stimulus with a response scoreboard for scr1_imem_arb
module tb_scr1_imem_arb;
  logic        clk, rst, m0_req, m1_req, s_req, s_req_ack, m0_req_ack, m1_req_ack;
  logic [31:0] m0_addr, m1_addr, s_addr, m0_rdata, m1_rdata, s_rdata;
  logic [1:0]  m0_resp, m1_resp, s_resp, outst_cnt;
  typedef struct {int port; logic [31:0] rdata; logic [1:0] resp;} exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int g[4];
  scr1_imem_arb #(.OUTST_DEPTH(2), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_req_ack(m0_req_ack), .m0_rdata(m0_rdata), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_req_ack(m1_req_ack), .m1_rdata(m1_rdata), .m1_resp(m1_resp),
    .s_req(s_req), .s_addr(s_addr), .s_req_ack(s_req_ack), .s_rdata(s_rdata), .s_resp(s_resp),
    .outst_cnt(outst_cnt)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    m0_req = 0; m1_req = 0; s_req_ack = 0; s_resp = 2'b00; s_rdata = 0;
  endtask
  task automatic drive_resp(input int p, input logic [31:0] d, input logic [1:0] r);
    s_resp = r; s_rdata = d;
    exp_q.push_back('{p, d, r});
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (m0_resp !== 2'b00 || m1_resp !== 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp got=m0:%0h/m1:%0h exp=none", m0_resp, m1_resp);
      end else begin
        e = exp_q.pop_front();
        chk("resp_m0", m0_resp, e.port == 0 ? e.resp : 2'b00);
        chk("rdata_m0", m0_rdata, e.port == 0 ? e.rdata : 32'h0);
        chk("resp_m1", m1_resp, e.port == 1 ? e.resp : 2'b00);
        chk("rdata_m1", m1_rdata, e.port == 1 ? e.rdata : 32'h0);
      end
    end
  end
  initial begin
`ifdef SCR1_IMEM_ARB_RR_EN
    g = '{1, 0, 1, 0};
`else
    g = '{0, 0, 0, 0};
`endif
    rst = 1; idle(); m0_req = 1; m0_addr = 32'h123; m1_addr = 0;
    @(negedge clk);
    chk("rst_s_req", s_req, 0); chk("rst_ack0", m0_req_ack, 0); chk("rst_cnt", outst_cnt, 0);
    chk("rst_s_addr", s_addr, 0);
    tick(); rst = 0; idle();
    // single fetch from port 0
    m0_req = 1; m0_addr = 32'h200; s_req_ack = 1;
    @(negedge clk);
    chk("t1_s_req", s_req, 1); chk("t1_s_addr", s_addr, 32'h200);
    chk("t1_ack0", m0_req_ack, 1); chk("t1_ack1", m1_req_ack, 0); chk("t1_cnt0", outst_cnt, 0);
    tick(); idle();
    @(negedge clk); chk("t1_cnt1", outst_cnt, 1);
    tick(); drive_resp(0, 32'hDEADBEEF, 2'b01);
    @(negedge clk); chk("t1_cnt1b", outst_cnt, 1);
    tick(); idle();
    @(negedge clk); chk("t1_cnt_done", outst_cnt, 0);
    // interleaved masters, RDY then ER
    tick(); m0_req = 1; m0_addr = 32'h100; s_req_ack = 1;
    @(negedge clk); chk("t4_ack0", m0_req_ack, 1); chk("t4_addr0", s_addr, 32'h100);
    tick(); m0_req = 0; m1_req = 1; m1_addr = 32'h800;
    @(negedge clk); chk("t4_ack1", m1_req_ack, 1); chk("t4_ack0_lo", m0_req_ack, 0); chk("t4_addr1", s_addr, 32'h800);
    tick(); idle(); drive_resp(0, 32'h11, 2'b01);
    @(negedge clk); chk("t4_cnt2", outst_cnt, 2);
    tick(); drive_resp(1, 32'h22, 2'b10);
    @(negedge clk); chk("t4_cnt1", outst_cnt, 1);
    tick(); idle();
    @(negedge clk); chk("t4_cnt0", outst_cnt, 0);
    // hold on port 0 while downstream stalls
    tick(); m0_req = 1; m1_req = 1; m0_addr = 32'h300; m1_addr = 32'h900;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_req", s_req, 1); chk("t2_hold_addr", s_addr, 32'h300);
      chk("t2_hold_ack0", m0_req_ack, 0); chk("t2_hold_ack1", m1_req_ack, 0);
      tick();
    end
    m0_req = 0;
    @(negedge clk); chk("t2_drop_req", s_req, 0);
    tick(); s_req_ack = 1;
    @(negedge clk); chk("t2_m1_addr", s_addr, 32'h900); chk("t2_m1_ack", m1_req_ack, 1);
    tick(); idle(); drive_resp(1, 32'h33, 2'b01);
    @(negedge clk); chk("t2_cnt1", outst_cnt, 1);
    tick(); idle();
    // full blocking and simultaneous accept/response
    m0_req = 1; m0_addr = 32'h400; s_req_ack = 1;
    @(negedge clk); chk("t3_c1_ack", m0_req_ack, 1); chk("t3_c1_cnt", outst_cnt, 0);
    tick();
    @(negedge clk); chk("t3_c2_ack", m0_req_ack, 1); chk("t3_c2_cnt", outst_cnt, 1);
    tick();
    @(negedge clk); chk("t3_full_req", s_req, 0); chk("t3_full_ack", m0_req_ack, 0); chk("t3_full_cnt", outst_cnt, 2);
    tick(); drive_resp(0, 32'hA1, 2'b01);
    @(negedge clk); chk("t3_pop_req", s_req, 0);
    tick(); s_resp = 0; s_rdata = 0;
    @(negedge clk); chk("t3_c5_cnt", outst_cnt, 1); chk("t3_c5_req", s_req, 1); chk("t3_c5_ack", m0_req_ack, 1);
    tick(); drive_resp(0, 32'hA2, 2'b01);
    @(negedge clk); chk("t3_c6_req", s_req, 0);
    tick(); drive_resp(0, 32'hA3, 2'b01);
    @(negedge clk); chk("t3_c7_ack", m0_req_ack, 1); chk("t3_c7_cnt", outst_cnt, 1);
    tick(); m0_req = 0; drive_resp(0, 32'hA4, 2'b01);
    @(negedge clk); chk("t3_c8_cnt", outst_cnt, 1);
    tick(); idle();
    @(negedge clk); chk("t3_cnt0", outst_cnt, 0);
    // continuous contention
    tick();
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m1_req = 1; m0_addr = 32'h500; m1_addr = 32'hA00; s_req_ack = 1;
      if (i > 0) drive_resp(g[i-1], 32'h50 + i, 2'b01);
      @(negedge clk);
      chk("t5_ack0", m0_req_ack, g[i] == 0); chk("t5_ack1", m1_req_ack, g[i] == 1);
      chk("t5_addr", s_addr, g[i] == 1 ? 32'hA00 : 32'h500);
      tick();
    end
    idle(); drive_resp(g[3], 32'h54, 2'b01);
    @(negedge clk); chk("t5_cnt1", outst_cnt, 1);
    tick(); idle();
    @(negedge clk); chk("t5_cnt0", outst_cnt, 0);
    // reset mid-transaction
    tick(); m0_req = 1; m0_addr = 32'h600; s_req_ack = 1;
    tick(); tick(); idle();
    @(negedge clk); chk("t6_cnt2", outst_cnt, 2);
    tick(); #2;
    rst = 1; m0_req = 1; m1_req = 1; s_req_ack = 1; s_resp = 2'b01; s_rdata = 32'hBB;
    #1;
    chk("t6_rst_cnt", outst_cnt, 0); chk("t6_rst_req", s_req, 0); chk("t6_rst_addr", s_addr, 0);
    chk("t6_rst_ack0", m0_req_ack, 0); chk("t6_rst_ack1", m1_req_ack, 0);
    chk("t6_rst_resp0", m0_resp, 0); chk("t6_rst_rdata0", m0_rdata, 0);
    tick(); rst = 0; m0_req = 0; m1_req = 0; s_req_ack = 0;
    @(negedge clk);
    chk("t6_drop_resp0", m0_resp, 0); chk("t6_drop_resp1", m1_resp, 0); chk("t6_drop_cnt", outst_cnt, 0);
    tick(); idle();
    @(negedge clk); chk("t6_cnt_final", outst_cnt, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
